// File: rtl/aes128_round_sequencer.sv
`timescale 1ns/1ps
// aes128_round_sequencer
//
// Iterative AES-128 encryption engine. A single registered 4x4 state matrix
// is run through one full AES round per clock. The round key for each round
// is derived on the fly from the previous one, so no key schedule storage is
// needed. Byte 0 of every 128-bit bus sits in bits [127:120]. Byte 4c+r is
// state[r][c] (column-major).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   plaintext/key pair offered by the source
//   in_ready   engine idle and able to take a pair
//   plaintext  128-bit input block
//   key        128-bit cipher key
//   out_valid  ciphertext available, held until out_ready
//   out_ready  sink accepts the ciphertext
//   ciphertext 128-bit result, stable while out_valid is high
//   busy       rounds in progress
//   round_idx  current round number 0..10 (0 while idle)
module aes128_round_sequencer #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     plaintext,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     ciphertext,
  output logic             busy,
  output logic [3:0]       round_idx
);

  generate
    if (NR != 10 || KEY_W != 128) begin : g_bad_params
      $error("aes128_round_sequencer only supports AES-128 (NR=10, KEY_W=128)");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [127:0]   st_q;
  logic [127:0]   rk_q;
  logic [7:0]     rcon_q;
  logic [127:0]   ct_q;

  logic           accept;
  logic           last_round;
  logic [127:0]   rk_next;
  logic [127:0]   round_out;

  // ---------------------------------------------------------------------
  // Round transforms
  // ---------------------------------------------------------------------
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 4; i++) begin
      o[127-32*i -: 32] = sub_word(s[127-32*i -: 32]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // One column; 3*a is written as xtime(a)^a.
  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] rk,
                                                  input logic [7:0]   rcon);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign accept     = in_valid && in_ready_q && (state_q == IDLE);
  assign last_round = (round_q == LAST_ROUND);
  assign rk_next    = next_round_key(rk_q, rcon_q);

  // The final round skips MixColumns.
  always_comb begin
    round_out = shift_rows(sub_bytes(st_q));
    if (!last_round) begin
      round_out = mix_columns(round_out);
    end
    round_out = round_out ^ rk_next;
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ROUND;
          round_d = 4'd1;
        end
      end
      ROUND: begin
        if (last_round) begin
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // in_ready is registered so it stays low while reset is asserted and
  // only rises on the first clock edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // ---------------------------------------------------------------------
  // State matrix, round key and rcon registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      rk_q   <= '0;
      rcon_q <= 8'h00;
      ct_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            st_q   <= plaintext ^ key;
            rk_q   <= key;
            rcon_q <= 8'h01;
          end
        end
        ROUND: begin
          st_q   <= round_out;
          rk_q   <= rk_next;
          rcon_q <= xtime(rcon_q);
          if (last_round) begin
            ct_q <= round_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
  assign busy       = (state_q == ROUND);
  assign round_idx  = round_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
`timescale 1ns/1ps
// Testbench for aes128_round_sequencer: directed FIPS-197 vectors, stall,
// back-to-back, mid-run reset and a randomized phase, all checked each cycle
// against a FIPS-style AES model whose S-box is derived from GF(2^8) inverses.
module tb_aes128_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] ciphertext;
  logic [3:0]   round_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes128_round_sequencer #(.NR(10), .KEY_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key),
    .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy), .round_idx(round_idx)
  );

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sb[256];
  logic [7:0]   rc_m[11];
  logic [127:0] m_rk[11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} >> (8 - n);
    return d[7:0];
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_tables();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc_m[0] = 8'h00;
    rc_m[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc_m[j] = gmul(rc_m[j-1], 8'h02);
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0)
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc_m[i/4], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ m_rk[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // ---------------- cycle-level expectation and compare ----------------
  // phase: 0 idle, 1..10 round in progress, 11 result waiting.
  int           phase = 0;
  bit           ready_m = 1'b0;
  logic [127:0] pend_ct = '0;
  logic [127:0] ct_m = '0;
  logic [127:0] txn_rk[11];
  bit [10:0]    ridx_seen = '0;
  int           ignored_valid = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_round_idx", 128'(round_idx), 128'(0));
      chk("rst_ciphertext", ciphertext, 128'(0));
      phase = 0; ready_m = 1'b0; ct_m = '0;
    end else begin
      chk("in_ready", 128'(in_ready), 128'(ready_m));
      chk("busy", 128'(busy), 128'(phase >= 1 && phase <= 10));
      chk("out_valid", 128'(out_valid), 128'(phase == 11));
      chk("round_idx", 128'(round_idx), 128'((phase == 11) ? 10 : phase));
      if (phase >= 1 && phase <= 10) begin
        chk("round_key", dut.rk_q, txn_rk[phase-1]);
        chk("rcon", 128'(dut.rcon_q), 128'(rc_m[phase]));
      end
      if (phase == 11) begin
        chk("ciphertext", ciphertext, ct_m);
        chk("round_key_10", dut.rk_q, txn_rk[10]);
      end
      if (round_idx <= 4'd10) ridx_seen[round_idx] = 1'b1;
      if (in_valid && phase != 0) ignored_valid++;
      // advance to what the next rising edge must produce
      if (phase == 0) begin
        if (in_valid && ready_m) begin
          pend_ct = aes_model(plaintext, key);
          txn_rk = m_rk;
          phase = 1;
        end
      end else if (phase < 10) begin
        phase++;
      end else if (phase == 10) begin
        phase = 11;
        ct_m = pend_ct;
      end else if (out_ready) begin
        phase = 0;
      end
      ready_m = (phase == 0);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && !in_ready; i++) step();
    chk("wait_in_ready", 128'(in_ready), 128'(1));
  endtask

  task automatic run_vec(input string name, input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] exp, input int stall);
    int cnt;
    wait_ready();
    in_valid = 1'b1; plaintext = pt; key = k; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      step();
      cnt++;
    end
    chk({name, "_latency"}, 128'(cnt), 128'(11));
    chk({name, "_ct"}, ciphertext, exp);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({name, "_stall"}, {ciphertext, 3'(0)} | 131'({out_valid, in_ready}), {exp, 3'(0)} | 131'(2'b10));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [127:0] got[$];
  logic [79:0]  rc_pack;

  initial begin
    bit fire_in, fire_out;
    int n_acc;
    build_tables();
    // model pins
    chk("model_zero_ct", aes_model('0, '0), CT_0);
    chk("model_zero_rk1", m_rk[1], 128'h62636363626363636263636362636363);
    chk("model_b_ct", aes_model(PT_B, KEY_B), CT_B);
    chk("model_b_rk10", m_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_c_ct", aes_model(PT_C, KEY_C), CT_C);
    for (int j = 1; j <= 10; j++) rc_pack[79-8*(j-1) -: 8] = rc_m[j];
    chk("model_rcon", 128'(rc_pack), 128'(80'h01020408102040801b36));

    repeat (3) step();
    rst_n = 1'b1;

    run_vec("vec1", '0, '0, CT_0, 0);
    run_vec("vec2", PT_B, KEY_B, CT_B, 0);
    run_vec("vec3", PT_C, KEY_C, CT_C, 20);

    // back-to-back with a mid-round plaintext/key change
    wait_ready();
    in_valid = 1'b1; out_ready = 1'b1; plaintext = PT_B; key = KEY_B;
    n_acc = 0;
    for (int cyc = 0; cyc < 80 && got.size() < 2; cyc++) begin
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) got.push_back(ciphertext);
      step();
      if (fire_in) begin
        n_acc++;
        if (n_acc == 1) begin plaintext = PT_C; key = KEY_C; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_count", 128'(got.size()), 128'(2));
    chk("b2b_first", (got.size() > 0) ? got[0] : 128'(0), CT_B);
    chk("b2b_second", (got.size() > 1) ? got[1] : 128'(0), CT_C);

    // reset in the middle of round 5
    wait_ready();
    in_valid = 1'b1; plaintext = '0; key = '0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && round_idx != 4'd5; i++) step();
    chk("pre_reset_round", 128'(round_idx), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 128'(busy), 128'(0));
    chk("async_rst_round_idx", 128'(round_idx), 128'(0));
    chk("async_rst_out_valid", 128'(out_valid), 128'(0));
    chk("async_rst_in_ready", 128'(in_ready), 128'(0));
    repeat (3) step();
    rst_n = 1'b1;
    run_vec("vec1_after_rst", '0, '0, CT_0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(2) == 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (15) step();

    chk("cov_round_idx", 128'(&ridx_seen), 128'(1));
    chk("cov_ignored_valid", 128'(ignored_valid > 0), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
